// File: rtl/s2_pkg.sv
// Shared definitions for the S2 serial-frame receiver and its neighbours.
// Holds the FSM state encoding and the default frame geometry.
package s2_pkg;

  localparam int DEF_ADDR_W     = 3;
  localparam int DEF_DATA_W     = 18;
  localparam int DEF_NUM_FRAMES = 8;
  localparam int FRAME_LEN      = DEF_ADDR_W + DEF_DATA_W;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Bits needed to count 0..n inclusive.
  function automatic int cnt_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/s2_shift_reg.sv
// MSB-first frame shift register with a saturating bit counter.
// Bits arriving after the register is full are dropped and flagged as overrun.
module s2_shift_reg
  import s2_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_start,
  input  logic              i_shift,
  input  logic              i_clear,
  input  logic              i_sd,
  output logic [ADDR_W-1:0] o_addr,
  output logic [DATA_W-1:0] o_data,
  output logic              o_full,
  output logic              o_overrun
);

  localparam int LEN = ADDR_W + DATA_W;
  localparam int CW  = cnt_width(LEN);

  logic [LEN-1:0] r_sr;
  logic [CW-1:0]  r_cnt;
  logic           r_ovr;

  always_ff @(posedge clk) begin
    if (rst || i_clear) begin
      r_sr  <= '0;
      r_cnt <= '0;
      r_ovr <= 1'b0;
    end else if (i_start) begin
      r_sr  <= {{(LEN-1){1'b0}}, i_sd};
      r_cnt <= CW'(1);
      r_ovr <= 1'b0;
    end else if (i_shift) begin
      if (r_cnt < CW'(LEN)) begin
        r_sr  <= {r_sr[LEN-2:0], i_sd};
        r_cnt <= r_cnt + CW'(1);
      end else begin
        r_ovr <= 1'b1;
      end
    end
  end

  // First received bit ends up at the top, so the address sits above the data.
  assign o_addr    = r_sr[LEN-1:DATA_W];
  assign o_data    = r_sr[DATA_W-1:0];
  assign o_full    = (r_cnt == CW'(LEN));
  assign o_overrun = r_ovr;

endmodule

// File: rtl/s2_receiver.sv
// Deserializes sen/sd frames into {addr,data} and writes them into RB2.
// Raises a sticky done after NUM_FRAMES good writes; malformed frames pulse frame_err.
module s2_receiver
  import s2_pkg::*;
#(
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int DATA_W     = DEF_DATA_W,
  parameter int NUM_FRAMES = DEF_NUM_FRAMES
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sen,
  input  logic              sd,
  output logic              RB2_RW,
  output logic [ADDR_W-1:0] RB2_A,
  output logic [DATA_W-1:0] RB2_D,
  input  logic [DATA_W-1:0] RB2_Q,
  output logic              S2_done,
  output logic              frame_err
);

  localparam int CW = cnt_width(NUM_FRAMES);

  state_t            r_state;
  logic [CW-1:0]     r_frame_cnt;
  logic              r_rw;
  logic [ADDR_W-1:0] r_a;
  logic [DATA_W-1:0] r_d;
  logic              r_done;
  logic              r_err;

  logic [ADDR_W-1:0] w_addr;
  logic [DATA_W-1:0] w_data;
  logic              w_full;
  logic              w_ovr;
  logic              w_start;
  logic              w_shift;
  logic              w_clear;
  logic [CW-1:0]     w_cnt_next;
  logic              w_last;
  logic              w_unused_q;

  assign w_unused_q = ^RB2_Q;

  always_comb begin
    w_cnt_next = r_frame_cnt + CW'(1);
    w_last     = (w_cnt_next == CW'(NUM_FRAMES));
    // A frame may begin in the WRITE cycle unless that write completes the set.
    w_start    = !sen && ((r_state == IDLE) || (r_state == WRITE && !w_last));
    w_shift    = !sen && (r_state == SHIFT);
    w_clear    = sen && (r_state == SHIFT);
  end

  s2_shift_reg #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) u_shift (
    .clk      (clk),
    .rst      (rst),
    .i_start  (w_start),
    .i_shift  (w_shift),
    .i_clear  (w_clear),
    .i_sd     (sd),
    .o_addr   (w_addr),
    .o_data   (w_data),
    .o_full   (w_full),
    .o_overrun(w_ovr)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_frame_cnt <= '0;
      r_rw        <= 1'b1;
      r_a         <= '0;
      r_d         <= '0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_err <= 1'b0;
      case (r_state)
        IDLE: begin
          if (!sen) r_state <= SHIFT;
        end
        SHIFT: begin
          if (sen) begin
            if (w_full && !w_ovr) begin
              r_a     <= w_addr;
              r_d     <= w_data;
              r_rw    <= 1'b0;
              r_state <= WRITE;
            end else begin
              r_err   <= 1'b1;
              r_state <= IDLE;
            end
          end
        end
        WRITE: begin
          r_rw        <= 1'b1;
          r_frame_cnt <= w_cnt_next;
          if (w_last) begin
            r_done  <= 1'b1;
            r_state <= DONE;
          end else if (!sen) begin
            r_state <= SHIFT;
          end else begin
            r_state <= IDLE;
          end
        end
        DONE: begin
          r_state <= DONE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign RB2_RW    = r_rw;
  assign RB2_A     = r_a;
  assign RB2_D     = r_d;
  assign S2_done   = r_done;
  assign frame_err = r_err;

endmodule

// File: tb/tb_s2_receiver.sv
// Randomized bench for s2_receiver: frames are driven on sen/sd and the observed
// RB2 writes, frame_err pulses and done flag are compared against a frame-level model.
module tb_s2_receiver;
  import s2_pkg::*;

  localparam int NUM = DEF_NUM_FRAMES;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sen = 1'b1;
  logic        sd  = 1'b0;
  logic [17:0] q   = '0;
  logic        rw;
  logic [2:0]  a;
  logic [17:0] d;
  logic        done;
  logic        ferr;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  typedef struct packed {
    logic [2:0]  a;
    logic [17:0] d;
    logic [31:0] c;
  } wr_t;

  // Monitor-owned observations
  wr_t  obs_q[$];
  int   err_total     = 0;
  int   last_err_cyc  = -1;
  int   done_rise_cyc = -1;
  logic done_prev     = 1'b0;

  // Model-owned expectations
  wr_t exp_q[$];
  int  m_vcnt   = 0;
  int  m_errs   = 0;
  int  obs_base = 0;
  int  err_base = 0;

  s2_receiver dut (
    .clk      (clk),
    .rst      (rst),
    .sen      (sen),
    .sd       (sd),
    .RB2_RW   (rw),
    .RB2_A    (a),
    .RB2_D    (d),
    .RB2_Q    (q),
    .S2_done  (done),
    .frame_err(ferr)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!rw) obs_q.push_back({a, d, 32'(cyc)});
    if (ferr) begin
      err_total    <= err_total + 1;
      last_err_cyc <= cyc;
    end
    if (done && !done_prev) done_rise_cyc <= cyc;
    done_prev <= done;
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      sen = 1'b1;
      sd  = 1'b0;
    end
    #1;
  endtask

  task automatic do_reset(input int n);
    @(negedge clk);
    rst = 1'b1;
    sen = 1'b1;
    sd  = 1'b0;
    repeat (n) @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    m_vcnt   = 0;
    m_errs   = 0;
    obs_base = obs_q.size();
    err_base = err_total;
  endtask

  // Drives one frame of len bits (first FRAME_LEN taken MSB-first from bits) and
  // updates the model: exactly FRAME_LEN bits is a write seen two cycles after the
  // last bit is driven; anything else is an error; all frames after done are ignored.
  task automatic send_frame(input int len, input logic [FRAME_LEN-1:0] bits,
                            input int gap, output int lc);
    for (int i = 0; i < len; i++) begin
      @(negedge clk);
      sen = 1'b0;
      sd  = (i < FRAME_LEN) ? bits[FRAME_LEN-1-i] : 1'($urandom_range(0, 1));
    end
    lc = cyc;
    if (m_vcnt < NUM) begin
      if (len == FRAME_LEN) begin
        exp_q.push_back({bits, 32'(lc + 2)});
        m_vcnt++;
      end else begin
        m_errs++;
      end
    end
    for (int g = 0; g < gap; g++) begin
      @(negedge clk);
      sen = 1'b1;
      sd  = 1'b0;
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (rw !== 1'b1) begin errors++; $display("FAIL reset_rw got %b want 1", rw); end
    checks++; if (a !== 3'd0) begin errors++; $display("FAIL reset_a got %0d want 0", a); end
    checks++; if (d !== 18'd0) begin errors++; $display("FAIL reset_d got %h want 0", d); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
    checks++; if (ferr !== 1'b0) begin errors++; $display("FAIL reset_err got %b want 0", ferr); end
    rst = 1'b0;
  endtask

  task automatic test_single();
    int lc;
    do_reset(2);
    send_frame(21, {3'b101, 18'h2A5A5}, 1, lc);
    idle(4);
    checks++;
    if (obs_q.size() - obs_base != 1) begin
      errors++; $display("FAIL single_count got %0d want 1", obs_q.size() - obs_base);
    end else begin
      checks += 3;
      if (obs_q[obs_base].a !== 3'd5) begin errors++; $display("FAIL single_addr got %0d want 5", obs_q[obs_base].a); end
      if (obs_q[obs_base].d !== 18'h2A5A5) begin errors++; $display("FAIL single_data got %h want 2a5a5", obs_q[obs_base].d); end
      if (obs_q[obs_base].c !== 32'(lc + 2)) begin errors++; $display("FAIL single_latency got %0d want %0d", obs_q[obs_base].c, lc + 2); end
    end
    checks++; if (err_total != err_base) begin errors++; $display("FAIL single_err got %0d want 0", err_total - err_base); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL single_done got %b want 0", done); end
    checks++; if (rw !== 1'b1 || a !== 3'd5 || d !== 18'h2A5A5) begin
      errors++; $display("FAIL single_hold got rw=%b a=%0d d=%h want 1/5/2a5a5", rw, a, d);
    end
  endtask

  task automatic test_eight_frames();
    int lc;
    int nobs;
    do_reset(2);
    for (int i = 0; i < NUM; i++) send_frame(21, {3'(i), 18'(i * 18'h01111)}, 1, lc);
    idle(3);
    checks++;
    if (obs_q.size() - obs_base != NUM) begin
      errors++; $display("FAIL eight_count got %0d want %0d", obs_q.size() - obs_base, NUM);
    end else begin
      for (int i = 0; i < NUM; i++) begin
        checks++;
        if (obs_q[obs_base+i].a !== 3'(i) || obs_q[obs_base+i].d !== 18'(i * 18'h01111)) begin
          errors++;
          $display("FAIL eight_write%0d got a=%0d d=%h want a=%0d d=%h", i, obs_q[obs_base+i].a,
                   obs_q[obs_base+i].d, i, 18'(i * 18'h01111));
        end
      end
      checks++;
      if (done_rise_cyc != int'(obs_q[obs_base+NUM-1].c) + 1) begin
        errors++; $display("FAIL eight_done_edge got %0d want %0d", done_rise_cyc, obs_q[obs_base+NUM-1].c + 1);
      end
    end
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL eight_done got %b want 1", done); end
    nobs = obs_q.size();
    send_frame(21, {3'd3, 18'h15555}, 2, lc);
    idle(3);
    checks++; if (obs_q.size() != nobs) begin errors++; $display("FAIL ninth_write got %0d extra want 0", obs_q.size() - nobs); end
    checks++; if (done !== 1'b1 || rw !== 1'b1) begin errors++; $display("FAIL ninth_state got done=%b rw=%b want 1/1", done, rw); end
  endtask

  task automatic test_short_frame();
    int lc1;
    int lc;
    logic [17:0] rd;
    rd = 18'($urandom);
    do_reset(2);
    send_frame(20, 21'($urandom), 1, lc1);
    send_frame(21, {3'd2, rd}, 1, lc);
    idle(3);
    checks++; if (err_total - err_base != 1) begin errors++; $display("FAIL short_err got %0d want 1", err_total - err_base); end
    checks++; if (last_err_cyc != lc1 + 2) begin errors++; $display("FAIL short_err_cycle got %0d want %0d", last_err_cyc, lc1 + 2); end
    checks++;
    if (obs_q.size() - obs_base != 1) begin
      errors++; $display("FAIL short_count got %0d want 1", obs_q.size() - obs_base);
    end else if (obs_q[obs_base].a !== 3'd2 || obs_q[obs_base].d !== rd) begin
      errors++; $display("FAIL short_write got a=%0d d=%h want a=2 d=%h", obs_q[obs_base].a, obs_q[obs_base].d, rd);
    end
    for (int i = 0; i < NUM - 2; i++) send_frame(21, 21'($urandom), 1, lc);
    idle(3);
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL short_early_done got %b want 0", done); end
    send_frame(21, 21'($urandom), 1, lc);
    idle(3);
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL short_done got %b want 1", done); end
  endtask

  task automatic test_long_frame();
    int lc;
    do_reset(2);
    send_frame(22, 21'($urandom), 2, lc);
    idle(3);
    checks++; if (err_total - err_base != 1) begin errors++; $display("FAIL long_err got %0d want 1", err_total - err_base); end
    checks++; if (obs_q.size() != obs_base) begin errors++; $display("FAIL long_write got %0d want 0", obs_q.size() - obs_base); end
    checks++; if (rw !== 1'b1) begin errors++; $display("FAIL long_rw got %b want 1", rw); end
    for (int i = 0; i < NUM - 1; i++) send_frame(21, 21'($urandom), 1, lc);
    idle(3);
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL long_early_done got %b want 0", done); end
    send_frame(21, 21'($urandom), 1, lc);
    idle(3);
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL long_done got %b want 1", done); end
  endtask

  task automatic test_reset_mid_frame();
    int lc;
    int b0;
    int e0;
    do_reset(2);
    b0 = obs_q.size();
    e0 = err_total;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      sen = 1'b0;
      sd  = 1'($urandom_range(0, 1));
    end
    do_reset(2);
    send_frame(21, {3'd7, 18'h3FFFF}, 1, lc);
    idle(4);
    checks++; if (err_total != e0) begin errors++; $display("FAIL rstmid_err got %0d want 0", err_total - e0); end
    checks++;
    if (obs_q.size() - b0 != 1) begin
      errors++; $display("FAIL rstmid_count got %0d want 1", obs_q.size() - b0);
    end else if (obs_q[b0].a !== 3'd7 || obs_q[b0].d !== 18'h3FFFF || obs_q[b0].c !== 32'(lc + 2)) begin
      errors++; $display("FAIL rstmid_write got a=%0d d=%h c=%0d want a=7 d=3ffff c=%0d",
                         obs_q[b0].a, obs_q[b0].d, obs_q[b0].c, lc + 2);
    end
  endtask

  task automatic test_back_to_back();
    int lc;
    do_reset(2);
    send_frame(21, 21'($urandom), 1, lc);
    send_frame(21, 21'($urandom), 1, lc);
    idle(3);
    checks++;
    if (obs_q.size() - obs_base != exp_q.size()) begin
      errors++; $display("FAIL b2b_count got %0d want %0d", obs_q.size() - obs_base, exp_q.size());
    end else begin
      foreach (exp_q[i]) begin
        checks++;
        if (obs_q[obs_base+i] !== exp_q[i]) begin
          errors++; $display("FAIL b2b_write%0d got a=%0d d=%h c=%0d want a=%0d d=%h c=%0d", i,
                             obs_q[obs_base+i].a, obs_q[obs_base+i].d, obs_q[obs_base+i].c,
                             exp_q[i].a, exp_q[i].d, exp_q[i].c);
        end
      end
    end
    checks++; if (err_total != err_base) begin errors++; $display("FAIL b2b_err got %0d want 0", err_total - err_base); end
  endtask

  task automatic test_random();
    int lc;
    int len;
    do_reset(2);
    for (int f = 0; f < 14; f++) begin
      len = ($urandom_range(0, 3) < 3) ? FRAME_LEN : int'($urandom_range(1, 26));
      send_frame(len, 21'($urandom), int'($urandom_range(1, 3)), lc);
    end
    idle(4);
    checks++;
    if (obs_q.size() - obs_base != exp_q.size()) begin
      errors++; $display("FAIL rand_count got %0d want %0d", obs_q.size() - obs_base, exp_q.size());
    end else begin
      foreach (exp_q[i]) begin
        checks++;
        if (obs_q[obs_base+i] !== exp_q[i]) begin
          errors++; $display("FAIL rand_write%0d got a=%0d d=%h c=%0d want a=%0d d=%h c=%0d", i,
                             obs_q[obs_base+i].a, obs_q[obs_base+i].d, obs_q[obs_base+i].c,
                             exp_q[i].a, exp_q[i].d, exp_q[i].c);
        end
      end
    end
    checks++; if (err_total - err_base != m_errs) begin errors++; $display("FAIL rand_err got %0d want %0d", err_total - err_base, m_errs); end
    checks++; if (done !== (m_vcnt >= NUM)) begin errors++; $display("FAIL rand_done got %b want %b", done, m_vcnt >= NUM); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_eight_frames();
    test_short_frame();
    test_long_frame();
    test_reset_mid_frame();
    test_back_to_back();
    for (int r = 0; r < 3; r++) test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
